// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and arithmetic helpers for the PDM microphone emulator.
//   DATA_W  signed PCM sample width
//   ACC_W   integrator width (DATA_W + 4 bits of headroom)
//   FS      modulator full-scale feedback magnitude, 2^(DATA_W-1)
//   CLIP    input clip level that keeps the second-order loop stable
//   sat()   clamp a widened sum back into the signed ACC_W range
//   clip()  clamp a PCM sample to +/-CLIP
package pdm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = DATA_W + 4;
    localparam int unsigned INTP_W = 16;

    typedef logic signed [DATA_W-1:0] pcm_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    // Two extra bits hold the sum of three ACC_W-range terms without overflow.
    typedef logic signed [ACC_W+1:0]  wide_t;

    localparam acc_t FS      = acc_t'(2 ** (DATA_W - 1));
    localparam pcm_t CLIP    = pcm_t'(28672);
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    function automatic acc_t sat(input wide_t v);
        acc_t r;
        if (v > wide_t'(ACC_MAX)) begin
            r = ACC_MAX;
        end else if (v < wide_t'(ACC_MIN)) begin
            r = ACC_MIN;
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    function automatic pcm_t clip(input pcm_t v);
        pcm_t r;
        if (v > CLIP) begin
            r = CLIP;
        end else if (v < -CLIP) begin
            r = -CLIP;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_mod2.sv
// sd_mod2: second-order sigma-delta modulator core (1-bit quantiser, +/-FS feedback).
//   i_clk   system clock
//   i_rst   synchronous active-high reset (clears both integrators and the output bit)
//   i_step  advance the loop by one output bit
//   i_x     signed input sample, already clipped by the caller
//   o_y     current output bit (registered, changes only on a step)
module sd_mod2
    import pdm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_step,
    input  logic signed [DATA_W-1:0] i_x,
    output logic                     o_y
);

    acc_t r_i1;
    acc_t r_i2;
    logic r_y;

    acc_t w_fb;
    acc_t w_i1_nxt;
    acc_t w_i2_nxt;

    always_comb begin
        w_fb     = r_y ? FS : -FS;
        w_i1_nxt = sat(wide_t'(r_i1) + wide_t'(i_x) - wide_t'(w_fb));
        // The second integrator consumes the freshly updated first integrator.
        w_i2_nxt = sat(wide_t'(r_i2) + wide_t'(w_i1_nxt) - wide_t'(w_fb));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_y  <= 1'b0;
        end else if (i_step) begin
            r_i1 <= w_i1_nxt;
            r_i2 <= w_i2_nxt;
            r_y  <= ~w_i2_nxt[ACC_W-1];
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/pdm_mic_emulator.sv
// pdm_mic_emulator: emulates a PDM microphone for in-FPGA testing of the decimation chain.
// PCM samples arrive over valid/ready, are held for interp_num+1 PDM bits each, and are
// converted to a 1-bit stream that is driven in step with the receiver's mic clock.
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_pcm_in      signed PCM sample
//   i_pcm_valid   i_pcm_in valid
//   o_pcm_ready   one-entry input buffer is empty (low during reset)
//   i_interp_num  PDM bits per sample, minus 1
//   i_mic_clk     PDM clock from the receiver, already in the i_clk domain
//   i_channel     1 = drive after rising edge (right), 0 = after falling edge (left)
//   o_data_out    PDM bit
//   o_data_oe     high while this emulator owns the data line
//   o_underrun    one-cycle pulse when a sample was due and none was available
module pdm_mic_emulator
    import pdm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic signed [DATA_W-1:0] i_pcm_in,
    input  logic                     i_pcm_valid,
    output logic                     o_pcm_ready,
    input  logic [INTP_W-1:0]        i_interp_num,
    input  logic                     i_mic_clk,
    input  logic                     i_channel,
    output logic                     o_data_out,
    output logic                     o_data_oe,
    output logic                     o_underrun
);

    logic              r_mic_clk_d;
    logic              r_buf_full;
    pcm_t              r_buf;
    pcm_t              r_cur;
    logic [INTP_W-1:0] r_bit_cntr;
    logic              r_data_oe;
    logic              r_underrun;

    logic w_rise;
    logic w_fall;
    logic w_act;
    logic w_inact;
    logic w_xfer;
    logic w_load;
    logic w_y;

    assign o_pcm_ready = ~i_rst & ~r_buf_full;

    always_comb begin
        w_rise  = i_mic_clk & ~r_mic_clk_d;
        w_fall  = ~i_mic_clk & r_mic_clk_d;
        w_act   = i_channel ? w_rise : w_fall;
        w_inact = i_channel ? w_fall : w_rise;
        w_xfer  = i_pcm_valid & o_pcm_ready;
        // '>=' rather than '==' so lowering interp_num mid-sample cannot strand the counter.
        w_load  = w_act & (r_bit_cntr >= i_interp_num);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mic_clk_d <= 1'b0;
            r_buf_full  <= 1'b0;
            r_buf       <= '0;
            r_cur       <= '0;
            r_bit_cntr  <= '0;
            r_data_oe   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_mic_clk_d <= i_mic_clk;
            r_underrun  <= 1'b0;

            if (w_act) begin
                r_data_oe <= 1'b1;
            end else if (w_inact) begin
                r_data_oe <= 1'b0;
            end

            if (w_act) begin
                if (w_load) begin
                    r_bit_cntr <= '0;
                end else begin
                    r_bit_cntr <= r_bit_cntr + 1'b1;
                end
            end

            if (w_load) begin
                if (r_buf_full) begin
                    r_cur      <= clip(r_buf);
                    r_buf_full <= 1'b0;
                end else if (w_xfer) begin
                    // Bypass: the sample goes straight to cur, the buffer stays empty.
                    r_cur <= clip(i_pcm_in);
                end else begin
                    // Nothing to load: keep emitting the previous sample.
                    r_underrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_buf_full <= 1'b1;
                r_buf      <= i_pcm_in;
            end
        end
    end

    // The modulator steps with the sample held before any load in the same cycle, so a
    // newly loaded sample is first used at the following active edge.
    sd_mod2 u_sd_mod2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_step (w_act),
        .i_x    (r_cur),
        .o_y    (w_y)
    );

    // The modulator bit is registered and only changes on an active edge, so it is the line.
    assign o_data_out = w_y;
    assign o_data_oe  = r_data_oe;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// tb_pdm_mic_emulator: self-checking bench for pdm_mic_emulator. An event-level model
// (integer arithmetic, one step per active mic clock edge, buffer as a flag + value) predicts
// every output each cycle; density tables and hand sequences add spec-level checks.
module tb_pdm_mic_emulator;

    localparam int FSV   = 32768;
    localparam int CLIPV = 28672;
    localparam int AMAX  = 524287;
    localparam int AMIN  = -524288;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] pcm_in = '0;
    logic               pcm_valid = 1'b0;
    logic               pcm_ready;
    logic [15:0]        interp_num = '0;
    logic               mic_clk = 1'b0;
    logic               channel = 1'b1;
    logic               data_out;
    logic               data_oe;
    logic               underrun;

    always #5 clk = ~clk;

    pdm_mic_emulator dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pcm_in     (pcm_in),
        .i_pcm_valid  (pcm_valid),
        .o_pcm_ready  (pcm_ready),
        .i_interp_num (interp_num),
        .i_mic_clk    (mic_clk),
        .i_channel    (channel),
        .o_data_out   (data_out),
        .o_data_oe    (data_oe),
        .o_underrun   (underrun)
    );

    // Reference model state
    int m_i1, m_i2, m_cur, m_cnt, m_buf;
    bit m_y, m_full, m_oe, m_under, m_mcd;

    int n_vec = 0;
    int n_err = 0;
    int mode  = 0;        // 0 hold inputs, 1 feed from queue, 2 random
    int feed_q[$];
    int n_act = 0;
    bit last_act, last_bit, last_under, last_oe;

    typedef struct {
        int pcm;
        int interp;
        bit chan;
        int lo;
        int hi;
    } dens_t;
    dens_t tbl[6];

    function automatic int sat(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic int clip(input int v);
        if (v > CLIPV) return CLIPV;
        if (v < -CLIPV) return -CLIPV;
        return v;
    endfunction

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_vec++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic model_update();
        bit rise, fall, act, inact, xfer, took;
        int fb, p;
        p = pcm_in;
        if (rst) begin
            m_i1 = 0; m_i2 = 0; m_cur = 0; m_cnt = 0; m_buf = 0;
            m_y = 0; m_full = 0; m_oe = 0; m_under = 0; m_mcd = 0;
            return;
        end
        rise  = mic_clk && !m_mcd;
        fall  = !mic_clk && m_mcd;
        m_mcd = mic_clk;
        act   = channel ? rise : fall;
        inact = channel ? fall : rise;
        xfer  = pcm_valid && !m_full;
        took  = 0;
        m_under = 0;
        if (act) begin
            fb   = m_y ? FSV : -FSV;
            m_i1 = sat(m_i1 + m_cur - fb);
            m_i2 = sat(m_i2 + m_i1 - fb);
            m_y  = (m_i2 >= 0);
            m_oe = 1;
            if (m_cnt >= int'(interp_num)) begin
                m_cnt = 0;
                if (m_full) begin
                    m_cur  = clip(m_buf);
                    m_full = 0;
                end else if (xfer) begin
                    m_cur = clip(p);
                    took  = 1;
                end else begin
                    m_under = 1;
                end
            end else begin
                m_cnt++;
            end
        end
        if (inact) m_oe = 0;
        if (xfer && !took) begin
            m_full = 1;
            m_buf  = p;
        end
        if (xfer && mode == 1 && feed_q.size() > 0) void'(feed_q.pop_front());
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic tick();
        if (mode == 1) begin
            if (feed_q.size() > 0) begin
                pcm_valid = 1'b1;
                pcm_in    = 16'(feed_q[0]);
            end else begin
                pcm_valid = 1'b0;
            end
        end else if (mode == 2) begin
            pcm_valid = 1'($urandom_range(0, 1));
            pcm_in    = 16'($urandom);
        end
        @(posedge clk);
        model_update();
        #1;
        chk1("data_out", data_out, m_y);
        chk1("data_oe", data_oe, m_oe);
        chk1("underrun", underrun, m_under);
        chk1("pcm_ready", pcm_ready, !rst && !m_full);
    endtask

    // Toggle mic_clk and hold it for n cycles; record what the edge produced.
    task automatic half(input int n);
        mic_clk  = ~mic_clk;
        last_act = (mic_clk == channel);
        tick();
        last_bit   = data_out;
        last_under = underrun;
        last_oe    = data_oe;
        if (last_act) n_act++;
        for (int k = 1; k < n; k++) tick();
    endtask

    task automatic do_reset();
        pcm_valid = 1'b0;
        mic_clk   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        n_act = 0;
        feed_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, unders;

        tbl[0] = '{pcm: 0,      interp: 0, chan: 1'b1, lo: 510, hi: 514};
        tbl[1] = '{pcm: 16384,  interp: 0, chan: 1'b1, lo: 765, hi: 771};
        tbl[2] = '{pcm: -16384, interp: 0, chan: 1'b1, lo: 253, hi: 259};
        tbl[3] = '{pcm: 32767,  interp: 0, chan: 1'b1, lo: 955, hi: 965};
        tbl[4] = '{pcm: -32768, interp: 0, chan: 1'b0, lo: 59,  hi: 69};
        tbl[5] = '{pcm: 16384,  interp: 3, chan: 1'b0, lo: 764, hi: 772};

        // Reset state
        do_reset();
        #1;
        chk1("reset_ready", pcm_ready, 1'b1);
        chk1("reset_oe", data_oe, 1'b0);
        chk1("reset_data", data_out, 1'b0);

        // Density table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mode       = 0;
            pcm_in     = 16'(tbl[i].pcm);
            interp_num = 16'(tbl[i].interp);
            channel    = tbl[i].chan;
            pcm_valid  = 1'b1;
            ones       = 0;
            unders     = 0;
            for (int h = 0; h < 4096 && n_act < 1024; h++) begin
                half(2);
                if (last_act) ones += int'(last_bit);
                unders += int'(last_under);
            end
            chk_rng($sformatf("density_%0d", i), ones, tbl[i].lo, tbl[i].hi);
            chk_rng($sformatf("no_underrun_%0d", i), unders, 0, 0);
        end

        // Handshake, underrun and bypass with interp_num = 3
        do_reset();
        mode       = 1;
        interp_num = 16'd3;
        channel    = 1'b1;
        feed_q     = '{100, 200, 300};
        for (int h = 0; h < 100 && n_act < 20; h++) begin
            half(3);
            if (last_act) chk1($sformatf("hs_underrun_e%0d", n_act), last_under,
                               (n_act == 16 || n_act == 20));
        end
        for (int h = 0; h < 100 && n_act < 24; h++) begin
            if (n_act == 23 && (~mic_clk) == channel) feed_q.push_back(400);
            half(3);
        end
        chk1("bypass_no_underrun", last_under, 1'b0);
        chk1("bypass_buf_empty", pcm_ready, 1'b1);
        for (int h = 0; h < 100 && n_act < 28; h++) half(3);
        chk1("retain_underrun", last_under, 1'b1);
        repeat (8) half(3);

        // Left channel with 26-cycle half-periods, then switch channel mid-stream
        do_reset();
        mode       = 0;
        pcm_valid  = 1'b1;
        pcm_in     = 16'sd8000;
        interp_num = 16'd0;
        channel    = 1'b0;
        half(26);
        chk1("ch0_idle_on_rise", data_oe, 1'b0);
        half(26);
        chk1("ch0_oe_after_fall", last_oe, 1'b1);
        chk1("ch0_first_bit", last_bit, 1'b1);
        half(26);
        chk1("ch0_release_on_rise", last_oe, 1'b0);
        half(26);
        channel = 1'b1;
        half(26);
        chk1("ch_switch_drive_rise", last_oe, 1'b1);
        half(26);
        chk1("ch_switch_release_fall", last_oe, 1'b0);

        // Reset mid-stream with the buffer full
        do_reset();
        pcm_valid  = 1'b1;
        pcm_in     = 16'sd20000;
        interp_num = 16'd3;
        channel    = 1'b1;
        repeat (5) half(2);
        chk1("pre_rst_oe", data_oe, 1'b1);
        chk1("pre_rst_full", pcm_ready, 1'b0);
        mic_clk = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("post_rst_oe", data_oe, 1'b0);
        chk1("post_rst_ready", pcm_ready, 1'b1);
        n_act = 0;
        half(2);
        chk1("post_rst_first_bit", last_bit, 1'b1);
        half(2);

        // Randomised stream: random data/valid, short half-periods, interp and channel changes
        do_reset();
        mode = 2;
        for (int r = 0; r < 700; r++) begin
            if ($urandom_range(0, 7) == 0) channel = ~channel;
            if ($urandom_range(0, 15) == 0) interp_num = 16'($urandom_range(0, 3));
            half(int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_mic_emulator.md
# pdm_mic_emulator

Emulates a digital PDM microphone so the CIC decimation chain can be exercised entirely inside the FPGA. Accepts signed PCM samples over a valid/ready handshake, converts them to a 1-bit pulse-density stream with a second-order sigma-delta modulator, and drives that stream in step with the microphone clock produced by the receiver. It sits on the microphone side of the PDM link, fed by a sample source (ROM, NCO or host interface), with its `data_out` connected to the receiver's `data_in`.

## Interface
- `DATA_W`, 16: signed PCM sample width.
- `ACC_W`, `DATA_W+4`: integrator width.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pcm_in`  in  DATA_W  signed PCM sample.
- `pcm_valid`  in  1  `pcm_in` valid.
- `pcm_ready`  out  1  emulator can accept a sample.
- `interp_num`  in  16  bits emitted per sample, minus 1.
- `mic_clk`  in  1  PDM clock from the receiver's `clk_out`; generated in the `clk` domain, so no synchronizer.
- `channel`  in  1  1 = right (drive after rising edge), 0 = left (drive after falling edge).
- `data_out`  out  1  PDM bit.
- `data_oe`  out  1  high while this emulator owns the data line.
- `underrun`  out  1  one-cycle pulse when a sample is due and none is available.

## Operation
- Edge detect: `mic_clk_d` is the previous-cycle `mic_clk`. `rise = mic_clk & ~mic_clk_d`, `fall = ~mic_clk & mic_clk_d`. Active edge is `rise` if `channel` = 1, otherwise `fall`. Inactive edge is the other one.
- Input buffer: one entry. `pcm_ready = ~buf_full`. A transfer occurs when `pcm_valid & pcm_ready`.
- Current sample `cur` is clipped on load to ±28672 (`CLIP`), which keeps the second-order loop stable.
- On each active edge, the modulator runs one step using `cur`:
  - `fb = y ? +FS : -FS`, with `FS = 2^(DATA_W-1)`.
  - `i1' = sat(i1 + cur - fb)`.
  - `i2' = sat(i2 + i1' - fb)`.
  - `y' = (i2' >= 0)`.
  - `sat()` clamps to the signed `ACC_W` range.
  - `data_out <= y'`.
  - `data_oe <= 1`.
- On each inactive edge: `data_oe <= 0`; `data_out` holds its value.
- Sample pacing, on each active edge:
  - If `bit_cntr >= interp_num`: set `bit_cntr <= 0` and load the next sample.
  - Otherwise: `bit_cntr++`.
  - The `>=` comparison makes lowering `interp_num` mid-stream safe.
- Load priority:
  1. Buffer full: load from the buffer and empty it.
  2. Else, a transfer in this same cycle: bypass it directly into `cur`; the buffer stays empty.
  3. Else: keep `cur` and pulse `underrun`.
- Every sample is emitted for exactly `interp_num+1` bits. A newly loaded sample is first used at the next active edge.
- Output density is `(1 + cur/FS)/2`.
- A change of `channel` takes effect at the next edge of `mic_clk`.

## Timing
- Reset values: `data_out` = 0, `data_oe` = 0, `underrun` = 0, `pcm_ready` = 0 while `rst` is high and 1 in the first cycle after. Internal state: `i1` = `i2` = 0, `y` = 0, `cur` = 0, `bit_cntr` = 0, buffer empty, `mic_clk_d` = 0.
- Reset mid-stream discards the buffered sample and the integrator state, and releases the line (`data_oe` = 0) in the next cycle.
- Latency:
  - Edge detect happens in cycle t, where `mic_clk` changed at the t-1 → t boundary.
  - `data_out` and `data_oe` update in cycle t+1.
  - With 26-cycle half-periods, data is stable 24 or more cycles before the receiver samples at the opposite edge.
- `underrun` is registered and high for exactly one cycle (t+1).
- `pcm_ready` falls the cycle after a transfer into the empty buffer. It rises the cycle after the buffer is consumed.
- Back-to-back `rise`/`fall` events in consecutive cycles are each processed. There is no minimum half-period beyond 1 cycle.

## Structure
- Package `pdm_pkg` holds `DATA_W`, `ACC_W`, `FS`, `CLIP`, and the `sat` function.
- Sub-module `sd_mod2` is the modulator core. Ports: `clk`, `rst`, `step`, `x[DATA_W]`, `y`. It holds `i1`, `i2` and `y`, and updates only when `step` is high.
- The top level holds the edge detect, the buffer, the pacing counter and the line drive.

## Test plan
- Bench `mic_clk`: 26 `clk` cycles per half-period.
- Zero input: `pcm_in` = 0 always valid, `interp_num` = 0, `channel` = 1 → over 1024 active edges the ones count is 512±2 and `underrun` never fires.
- Density:
  - `pcm_in` = +16384 → ones 768±3 per 1024 bits.
  - `pcm_in` = −16384 → ones 256±3.
  - `pcm_in` = +32767 → clipped; density 0.9375±0.005 and integrators never saturate-stick.
- Handshake:
  - `interp_num` = 3, samples 100, 200, 300 → each is loaded after exactly 4 active edges.
  - `pcm_ready` is low while the buffer is full.
  - Bypass path: a sample offered in the load cycle with an empty buffer is loaded the same cycle, with no `underrun`.
- Underrun: stop `pcm_valid` → one `underrun` pulse per `interp_num+1` active edges, and `cur` is retained.
- Channel: `channel` = 0 → `data_out` changes 1 cycle after `mic_clk` falls; `data_oe` is high only while `mic_clk` is low. Toggle `channel` mid-stream → the switch happens at the next edge.
- Reset mid-stream with the buffer full → the next cycle shows `data_oe` = 0 and `pcm_ready` = 1, and the first post-reset bit matches a fresh zero-state run.
